// File: rtl/main_mem_if.sv
// -----------------------------------------------------------------------------
// main_mem_if : request/response bundle for the main_mem memory model.
//
// Signals (bit 0 is the MSB on every bus):
//   addr     [0:31] byte address of the request (low two bits ignored)
//   data_in  [0:31] write data for the current beat
//   data_out [0:31] registered read data
//   acc_size [0:1]  burst length code: 00=1, 01=4, 10=8, 11=16 words
//   wren            1=write, 0=read
//   enable          request qualifier
//   busy            high while a multi-beat transaction is in progress
//
// Handshake: a request is accepted on any rising edge where the memory is
// idle (busy=0) and enable=1; addr/acc_size/wren are captured at that edge.
// There is no back-pressure beyond busy: while busy=1 the request inputs are
// ignored (except data_in on a write burst, which supplies one beat per edge),
// and a new request may be presented on the edge right after busy falls.
// -----------------------------------------------------------------------------
interface main_mem_if;
    logic [0:31] addr;
    logic [0:31] data_in;
    logic [0:31] data_out;
    logic [0:1]  acc_size;
    logic        wren;
    logic        enable;
    logic        busy;

    modport master (
        output addr, data_in, acc_size, wren, enable,
        input  data_out, busy
    );

    modport slave (
        input  addr, data_in, acc_size, wren, enable,
        output data_out, busy
    );
endinterface

// File: rtl/main_mem.sv
// -----------------------------------------------------------------------------
// main_mem : word-wide, big-endian main memory model with single-word and
// fixed-length burst (1/4/8/16 word) reads and writes.
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous, active-high reset (memory contents are kept)
//   mif         main_mem_if.slave request/response bundle
//   o_dbg_state current FSM state (0=IDLE, 1=BURST) for observation
//
// Parameters:
//   BASE_ADDR   byte address that maps to word 0
//   DEPTH_WORDS number of 32-bit words (power of two)
//
// Build option:
//   MAIN_MEM_RANGE_CHECK_EN  when defined, beats outside
//   [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) are dropped on write and read back
//   as 32'hDEAD_BEEF; when undefined the word index wraps modulo DEPTH_WORDS.
// -----------------------------------------------------------------------------
module main_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
    parameter int          DEPTH_WORDS = 4096
) (
    input  logic       clock,
    input  logic       reset,
    main_mem_if.slave  mif,
    output logic       o_dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);
`ifdef MAIN_MEM_RANGE_CHECK_EN
    // Full word offset is kept so out-of-range beats can be recognised.
    localparam int OW = 32;
`else
    // Only the low index bits matter; this makes the wrap automatic.
    localparam int OW = AW;
`endif

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [OW-1:0] r_next_off;   // word offset of the next burst beat
    logic [3:0]    r_left;       // beats still to perform after the current one
    logic          r_wren;       // direction latched at acceptance
    logic [0:31]   r_data_out;

    logic [0:31]   r_mem [0:DEPTH_WORDS-1];

    logic [31:0]   w_req_diff;
    logic [OW-1:0] w_req_off;
    logic [OW-1:0] w_beat_off;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_req_left;
    logic          w_do_beat;
    logic          w_beat_wr;
    logic          w_in_range;
    logic          w_unused_bits;

    // Byte offset from the base; the two low address bits never select a word.
    assign w_req_diff = mif.addr - BASE_ADDR;

`ifdef MAIN_MEM_RANGE_CHECK_EN
    assign w_req_off     = {2'b00, w_req_diff[31:2]};
    assign w_unused_bits = ^w_req_diff[1:0];
    assign w_in_range    = (w_beat_off < 32'(DEPTH_WORDS));
`else
    assign w_req_off     = w_req_diff[AW+1:2];
    assign w_unused_bits = ^{w_req_diff[31:AW+2], w_req_diff[1:0]};
    assign w_in_range    = 1'b1;
`endif

    assign w_idx = w_beat_off[AW-1:0];

    // Number of beats remaining after the accept beat.
    always_comb begin
        w_req_left = 4'd0;
        case (mif.acc_size)
            2'b00:   w_req_left = 4'd0;
            2'b01:   w_req_left = 4'd3;
            2'b10:   w_req_left = 4'd7;
            default: w_req_left = 4'd15;
        endcase
    end

    // Next state and per-edge beat selection. A beat happens on the accept
    // edge (offset from the live address) and on every BURST edge (offset
    // from the latched running pointer).
    always_comb begin
        w_next_state = r_state;
        w_do_beat    = 1'b0;
        w_beat_wr    = r_wren;
        w_beat_off   = r_next_off;
        case (r_state)
            ST_IDLE: begin
                if (mif.enable) begin
                    w_do_beat  = 1'b1;
                    w_beat_wr  = mif.wren;
                    w_beat_off = w_req_off;
                    if (w_req_left != 4'd0) begin
                        w_next_state = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                w_do_beat = 1'b1;
                if (r_left == 4'd1) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Burst bookkeeping and registered read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_out <= '0;
            r_left     <= 4'd0;
            r_next_off <= '0;
            r_wren     <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (mif.enable) begin
                    r_left <= w_req_left;
                    r_wren <= mif.wren;
                end
            end else begin
                r_left <= r_left - 4'd1;
            end
            if (w_do_beat) begin
                r_next_off <= w_beat_off + OW'(1);
                if (!w_beat_wr) begin
                    r_data_out <= w_in_range ? r_mem[w_idx] : 32'hDEAD_BEEF;
                end
            end
        end
    end

    // Storage is never cleared; an edge with reset high writes nothing,
    // which is what aborts a write burst in place.
    always_ff @(posedge clock) begin
        if (!reset && w_do_beat && w_beat_wr && w_in_range) begin
            r_mem[w_idx] <= mif.data_in;
        end
    end

    assign mif.data_out = r_data_out;
    assign mif.busy     = (r_state == ST_BURST);
    assign o_dbg_state  = (r_state == ST_BURST);

endmodule

// File: tb/tb_main_mem.sv
module tb_main_mem;

    localparam logic [31:0] BASE  = 32'h8002_0000;
    localparam int          DEPTH = 4096;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic dbg_state;

    main_mem_if mif();

    main_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .mif         (mif),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] model_mem [0:DEPTH-1];
    logic [31:0] wr_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic        busy_q[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int beats(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    // Word offset of beat k of a transaction at byte address a.
    function automatic logic [31:0] beat_off(input logic [31:0] a, input int k);
        logic [31:0] d;
        d = a - BASE;
        return (d >> 2) + 32'(k);
    endfunction

    function automatic logic model_hit(input logic [31:0] off);
`ifdef MAIN_MEM_RANGE_CHECK_EN
        return off < 32'(DEPTH);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] off;
        for (int k = 0; k < beats(sz); k++) begin
            off = beat_off(a, k);
            if (model_hit(off)) model_mem[off % DEPTH] = wr_q[k];
        end
    endtask

    task automatic model_expect(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] off;
        exp_q.delete();
        for (int k = 0; k < beats(sz); k++) begin
            off = beat_off(a, k);
            exp_q.push_back(model_hit(off) ? model_mem[off % DEPTH] : 32'hDEAD_BEEF);
        end
    endtask

    task automatic fill_wr(input int n);
        wr_q.delete();
        for (int k = 0; k < n; k++) wr_q.push_back($urandom);
    endtask

    // ---------------- driver ----------------
    // Issues one transaction; during the burst the request inputs carry junk
    // (or enable is forced low) since they must be ignored.
    task automatic do_xfer(input logic [31:0] a, input logic [1:0] sz,
                           input logic wr, input logic drop_en);
        int n;
        n = beats(sz);
        obs_q.delete();
        busy_q.delete();
        mif.enable   = 1'b1;
        mif.wren     = wr;
        mif.addr     = a;
        mif.acc_size = sz;
        mif.data_in  = wr ? wr_q[0] : $urandom;
        tick();
        obs_q.push_back(mif.data_out);
        busy_q.push_back(mif.busy);
        for (int k = 1; k < n; k++) begin
            mif.enable   = drop_en ? 1'b0 : 1'($urandom_range(0, 1));
            mif.wren     = 1'($urandom_range(0, 1));
            mif.addr     = $urandom;
            mif.acc_size = 2'($urandom_range(0, 3));
            mif.data_in  = wr ? wr_q[k] : $urandom;
            tick();
            obs_q.push_back(mif.data_out);
            busy_q.push_back(mif.busy);
        end
        mif.enable  = 1'b0;
        mif.wren    = 1'b0;
        mif.addr    = $urandom;
        mif.data_in = $urandom;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        mif.enable   = 1'b1;
        mif.wren     = 1'b0;
        mif.addr     = BASE;
        mif.acc_size = 2'b11;
        mif.data_in  = $urandom;
        tick();
        tick();
        tests_run++;
        if (mif.data_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data_out: got %h expected 00000000", mif.data_out);
        end
        tests_run++;
        if (mif.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b expected 0", mif.busy);
        end
        tests_run++;
        if (dbg_state !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got %b expected 0", dbg_state);
        end
        mif.enable = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        wr_q.delete();
        wr_q.push_back(32'h2784_FFE0);
        do_xfer(BASE, 2'b00, 1'b1, 1'b0);
        model_write(BASE, 2'b00);
        tests_run++;
        if (busy_q[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_wr_busy: got %b expected 0", busy_q[0]);
        end
        do_xfer(BASE, 2'b00, 1'b0, 1'b0);
        tests_run++;
        if (obs_q[0] !== 32'h2784_FFE0) begin
            tests_failed++;
            $display("FAIL single_rd_data: got %h expected 2784ffe0", obs_q[0]);
        end
        tests_run++;
        if (busy_q[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_rd_busy: got %b expected 0", busy_q[0]);
        end
    endtask

    task automatic test_prefill();
        for (int i = 0; i < DEPTH / 16; i++) begin
            fill_wr(16);
            do_xfer(BASE + 32'(64 * i), 2'b11, 1'b1, 1'b0);
            model_write(BASE + 32'(64 * i), 2'b11);
        end
    endtask

    // Write then read back-to-back for 4/8/16-word bursts.
    task automatic test_bursts();
        logic [31:0] addrs [3];
        logic [31:0] wr_copy[$];
        int n;
        addrs[0] = 32'h8002_0004;
        addrs[1] = 32'h8002_0014;
        addrs[2] = 32'h8002_0034;
        for (int s = 1; s <= 3; s++) begin
            n = beats(2'(s));
            fill_wr(n);
            wr_copy = wr_q;
            do_xfer(addrs[s-1], 2'(s), 1'b1, 1'b0);
            model_write(addrs[s-1], 2'(s));
            for (int k = 0; k < n; k++) begin
                tests_run++;
                if (busy_q[k] !== (k < n - 1)) begin
                    tests_failed++;
                    $display("FAIL burst%0d_wr_busy beat %0d: got %b expected %b",
                             n, k, busy_q[k], (k < n - 1));
                end
            end
            do_xfer(addrs[s-1], 2'(s), 1'b0, 1'b0);
            for (int k = 0; k < n; k++) begin
                tests_run++;
                if (obs_q[k] !== wr_copy[k]) begin
                    tests_failed++;
                    $display("FAIL burst%0d_rd_data beat %0d: got %h expected %h",
                             n, k, obs_q[k], wr_copy[k]);
                end
                tests_run++;
                if (busy_q[k] !== (k < n - 1)) begin
                    tests_failed++;
                    $display("FAIL burst%0d_rd_busy beat %0d: got %b expected %b",
                             n, k, busy_q[k], (k < n - 1));
                end
            end
        end
    endtask

    task automatic test_drop_enable();
        logic [31:0] a;
        logic [31:0] wr_copy[$];
        a = BASE + 32'h200;
        fill_wr(8);
        wr_copy = wr_q;
        do_xfer(a, 2'b10, 1'b1, 1'b1);
        model_write(a, 2'b10);
        do_xfer(a, 2'b10, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tests_run++;
            if (obs_q[k] !== wr_copy[k]) begin
                tests_failed++;
                $display("FAIL drop_enable beat %0d: got %h expected %h", k, obs_q[k], wr_copy[k]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] a;
        logic [31:0] off;
        a = BASE + 32'd400;
        fill_wr(16);
        mif.enable   = 1'b1;
        mif.wren     = 1'b1;
        mif.addr     = a;
        mif.acc_size = 2'b11;
        mif.data_in  = wr_q[0];
        tick();
        mif.enable  = 1'b0;
        mif.addr    = $urandom;
        mif.data_in = wr_q[1];
        tick();
        reset       = 1'b1;
        mif.data_in = wr_q[2];
        tick();
        tests_run++;
        if (mif.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_busy: got %b expected 0", mif.busy);
        end
        tests_run++;
        if (mif.data_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL midrst_data_out: got %h expected 00000000", mif.data_out);
        end
        reset = 1'b0;
        tick();
        // Only beats 0 and 1 landed.
        for (int k = 0; k < 2; k++) begin
            off = beat_off(a, k);
            model_mem[off % DEPTH] = wr_q[k];
        end
        model_expect(a, 2'b11);
        do_xfer(a, 2'b11, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            tests_run++;
            if (obs_q[k] !== exp_q[k]) begin
                tests_failed++;
                $display("FAIL midrst_readback beat %0d: got %h expected %h", k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_idle_hold();
        logic [31:0] held;
        model_expect(BASE + 32'd800, 2'b00);
        held = exp_q[0];
        do_xfer(BASE + 32'd800, 2'b00, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            mif.enable  = 1'b0;
            mif.wren    = 1'($urandom_range(0, 1));
            mif.addr    = BASE + 32'(4 * $urandom_range(0, 15));
            mif.data_in = $urandom;
            tick();
            tests_run++;
            if (mif.data_out !== held || mif.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_hold cycle %0d: got %h/%b expected %h/0",
                         c, mif.data_out, mif.busy, held);
            end
        end
        mif.wren = 1'b0;
    endtask

    task automatic test_range();
        logic [31:0] v;
        v = $urandom;
`ifdef MAIN_MEM_RANGE_CHECK_EN
        do_xfer(BASE - 32'd4, 2'b00, 1'b0, 1'b0);
        tests_run++;
        if (obs_q[0] !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL range_low_read: got %h expected deadbeef", obs_q[0]);
        end
        wr_q.delete();
        wr_q.push_back(v);
        do_xfer(BASE + 32'(4 * DEPTH), 2'b00, 1'b1, 1'b0);
        model_expect(BASE, 2'b00);
        do_xfer(BASE, 2'b00, 1'b0, 1'b0);
        tests_run++;
        if (obs_q[0] !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL range_drop_write: got %h expected %h", obs_q[0], exp_q[0]);
        end
`else
        wr_q.delete();
        wr_q.push_back(v);
        do_xfer(BASE + 32'(4 * DEPTH), 2'b00, 1'b1, 1'b0);
        model_write(BASE + 32'(4 * DEPTH), 2'b00);
        do_xfer(BASE, 2'b00, 1'b0, 1'b0);
        tests_run++;
        if (obs_q[0] !== v) begin
            tests_failed++;
            $display("FAIL range_alias: got %h expected %h", obs_q[0], v);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  sz;
        logic        wr;
        int          w;
        int          n;
        for (int t = 0; t < 150; t++) begin
            sz = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            w  = int'($urandom_range(0, DEPTH + 40)) - 20;
            a  = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
            n  = beats(sz);
            fill_wr(n);
            if (!wr) model_expect(a, sz);
            do_xfer(a, sz, wr, 1'b0);
            if (wr) begin
                model_write(a, sz);
            end else begin
                for (int k = 0; k < n; k++) begin
                    tests_run++;
                    if (obs_q[k] !== exp_q[k]) begin
                        tests_failed++;
                        $display("FAIL random_rd txn %0d beat %0d addr %h: got %h expected %h",
                                 t, k, a, obs_q[k], exp_q[k]);
                    end
                end
            end
            for (int k = 0; k < n; k++) begin
                tests_run++;
                if (busy_q[k] !== (k < n - 1)) begin
                    tests_failed++;
                    $display("FAIL random_busy txn %0d beat %0d: got %b expected %b",
                             t, k, busy_q[k], (k < n - 1));
                end
            end
        end
    endtask

    task automatic test_full_readback();
        logic [31:0] a;
        for (int i = 0; i < DEPTH / 16; i++) begin
            a = BASE + 32'(64 * i);
            model_expect(a, 2'b11);
            do_xfer(a, 2'b11, 1'b0, 1'b0);
            for (int k = 0; k < 16; k++) begin
                tests_run++;
                if (obs_q[k] !== exp_q[k]) begin
                    tests_failed++;
                    $display("FAIL readback word %0d: got %h expected %h", 16 * i + k, obs_q[k], exp_q[k]);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        mif.enable   = 1'b0;
        mif.wren     = 1'b0;
        mif.addr     = '0;
        mif.acc_size = '0;
        mif.data_in  = '0;
        test_reset();
        test_single();
        test_prefill();
        test_bursts();
        test_drop_enable();
        test_reset_mid_burst();
        test_idle_hold();
        test_range();
        test_random();
        test_full_readback();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/main_mem.md
Name: main_mem

Overview:
Word-wide, big-endian main memory model for the MIPS processor. It supports single-word and fixed-length burst reads and writes, selected by an access-size code. Program images are loaded by writing them into it starting at BASE_ADDR. It provides a busy indication while a burst is in progress.

Parameters:
BASE_ADDR, 32'h8002_0000, byte address that maps to word 0 of the array.
DEPTH_WORDS, 4096, number of 32-bit words stored (power of two).

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
addr  input  32 [0:31]  byte address; bits [30:31] are ignored (word aligned)
data_in  input  32 [0:31]  write data for the current beat
data_out  output  32 [0:31]  read data, registered
acc_size  input  2 [0:1]  burst length: 00=1 word, 01=4, 10=8, 11=16
wren  input  1  1=write, 0=read; sampled when a request is accepted
busy  output  1  high while a multi-beat transaction is in progress
enable  input  1  request qualifier

Behaviour:
- The block uses one clock. Reset is synchronous and active-high. At reset: data_out=0, busy=0, state=IDLE. Memory contents are not cleared.
- Bit 0 is the MSB on all buses (big-endian [0:31] ordering).
- Word index = ((addr - BASE_ADDR) >> 2) mod DEPTH_WORDS. The subtraction and shift are 32-bit unsigned.
- Request acceptance: at a rising edge with state=IDLE and enable=1, the block latches addr, acc_size and wren. Beat count N = 1, 4, 8 or 16.
- Write, beat 0: data_in is written to word[idx] at the accept edge.
- Write, beats 1..N-1: data_in is written to word[idx+k] on each following edge. addr is ignored after acceptance. The index wraps modulo DEPTH_WORDS.
- Read: at the accept edge, data_out <= word[idx]. On each of the next N-1 edges, data_out <= word[idx+k]. data_out holds its last value afterwards until the next read beat.
- A word written at edge T is readable by a read accepted at edge T+1 or later (no write-to-read hazard).
- busy is 1 from the accept edge of any transaction with N>1 until the edge that performs the last beat. That edge clears busy. Single-word accesses never raise busy.
- FSM states: IDLE and BURST.
  - IDLE -> BURST on acceptance with N>1.
  - BURST counts beats and returns to IDLE after beat N-1.
- While in BURST, enable, wren, acc_size and addr are ignored. A burst always completes; enable=0 does not abort it.
- In IDLE with enable=0, nothing is written and data_out holds its value.
- Back-to-back: a new request can be accepted on the edge immediately after the last beat.
- Reset asserted mid-burst: the burst aborts at that edge. Beats already written remain in memory; no further beats are written.
- Writes during a read burst are not possible. The direction is fixed at acceptance.

Optional Feature:
MAIN_MEM_RANGE_CHECK_EN:
- Defined: any beat whose byte address lies outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) is dropped on write, and returns 32'hDEAD_BEEF on read. No wrap.
- Undefined: the index wraps modulo DEPTH_WORDS as described above.

Test Plan:
- Reset, then a single write of 32'h2784FFE0 to 0x80020000, then a single read of the same address -> data_out = 32'h2784FFE0 after the read accept edge; busy stays 0 throughout.
- 4-word burst write at 0x80020004 with data A,B,C,D on consecutive edges, then a 4-word burst read at 0x80020004 -> data_out = A,B,C,D on 4 consecutive edges; busy high for exactly 3 cycles per burst.
- 8-word and 16-word burst writes then reads at 0x80020014 and 0x80020034 -> all words match in order; busy low after the 8th/16th beat; a new request is accepted on the next edge.
- Burst write with enable dropped and addr changed mid-burst -> all N beats are written to the originally latched addresses.
- Reset asserted on beat 2 of a 16-word write, then read the 16 words -> words 0-1 hold the new data, words 2-15 keep their prior values; busy=0 and data_out=0 after reset.
- With MAIN_MEM_RANGE_CHECK_EN defined, read at BASE_ADDR-4 -> 32'hDEADBEEF; without it, a write to BASE_ADDR+4*DEPTH_WORDS aliases to word 0.
